// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the BRAM port arbiter.
//   arb_state_t : IDLE / ISSUE / COMPLETE state encoding
//   OWNER_CPU / OWNER_PER : owner identifiers for the latched transaction
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_PER = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, BRAM and status signals of the arbiter.
//   CPU side : cpu_req/we/addr/wdata in, cpu_ack/rdata out
//   PER side : per_req/we/addr/wdata in, per_ack/rdata out
//   BRAM     : mem_addr/wdata/we out, mem_rdata in
//   status   : busy, owner out
// master = arbiter view, slave = environment (requesters + BRAM) view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              per_req;
  logic              per_we;
  logic [ADDR_W-1:0] per_addr;
  logic [DATA_W-1:0] per_wdata;
  logic              per_ack;
  logic [DATA_W-1:0] per_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  per_req, per_we, per_addr, per_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, per_ack, per_rdata,
    output mem_addr, mem_wdata, mem_we,
    output busy, owner
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output per_req, per_we, per_addr, per_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, per_ack, per_rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  busy, owner
  );

endinterface

// File: rtl/mem_port_arbiter_priority.sv
// mem_arb_priority: winner select with fixed CPU priority and a starvation
// counter that forces a peripheral grant after STARVE_LIMIT consecutive CPU
// grants while the peripheral is waiting.
//   clk, rst      : clock, asynchronous active-low reset
//   i_arbitrate   : high in cycles whose closing edge is an arbitration point
//   i_cpu_req     : CPU request level
//   i_per_req     : peripheral request level
//   o_grant       : some requester wins at this arbitration
//   o_winner      : OWNER_CPU / OWNER_PER (meaningful only with o_grant)
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arbitrate,
  input  logic i_cpu_req,
  input  logic i_per_req,
  output logic o_grant,
  output logic o_winner
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_per;

  always_comb begin
    w_force_per = i_per_req && (r_starve_cnt == LIMIT);
    o_grant     = i_cpu_req || i_per_req;
    o_winner    = (w_force_per || !i_cpu_req) ? OWNER_PER : OWNER_CPU;
  end

  // Counts CPU wins only while the peripheral is actually waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (i_arbitrate) begin
      if (!i_per_req || o_winner == OWNER_PER) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single BRAM address/data port between the CPU
// and a peripheral/DMA master, one transaction at a time.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_port_arbiter_if.master -- requester handshakes, BRAM port,
//          busy (ISSUE/COMPLETE) and owner (latched transaction's requester)
// Sequence: arbitrate (leaving IDLE/COMPLETE) -> ISSUE (BRAM driven from
// latched registers) -> COMPLETE (owner's ack pulse, read data valid).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_owner;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_per_rdata;

  logic              w_arbitrate;
  logic              w_grant;
  logic              w_winner;

  assign w_arbitrate = (r_state == IDLE) || (r_state == COMPLETE);

  mem_arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_priority (
    .clk         (clk),
    .rst         (rst),
    .i_arbitrate (w_arbitrate),
    .i_cpu_req   (bus.cpu_req),
    .i_per_req   (bus.per_req),
    .o_grant     (w_grant),
    .o_winner    (w_winner)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, COMPLETE: w_next_state = w_grant ? ISSUE : IDLE;
      ISSUE:          w_next_state = COMPLETE;
      default:        w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // The latch only loads on the edge entering ISSUE, so driving the BRAM
  // address/data straight from it holds them stable outside ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_owner <= OWNER_CPU;
    end else if (w_arbitrate && w_grant) begin
      r_owner <= w_winner;
      if (w_winner == OWNER_PER) begin
        r_we    <= bus.per_we;
        r_addr  <= bus.per_addr;
        r_wdata <= bus.per_wdata;
      end else begin
        r_we    <= bus.cpu_we;
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_rdata <= '0;
      r_per_rdata <= '0;
    end else if (r_state == ISSUE && !r_we) begin
      if (r_owner == OWNER_PER) r_per_rdata <= bus.mem_rdata;
      else                      r_cpu_rdata <= bus.mem_rdata;
    end
  end

  // Decoded from state so reset kills mem_we and any pending ack at once.
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_we    = (r_state == ISSUE) && r_we;
  assign bus.cpu_ack   = (r_state == COMPLETE) && (r_owner == OWNER_CPU);
  assign bus.per_ack   = (r_state == COMPLETE) && (r_owner == OWNER_PER);
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.per_rdata = r_per_rdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic          per;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   per_ack_cnt = 0;
  int   per_ack_base;
  exp_t sbq[$];
  logic [DW-1:0] mem [0:511];

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // BRAM model: read data follows the presented address, writes on the edge.
  assign bus.mem_rdata = mem[bus.mem_addr[8:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[8:0]] <= bus.mem_wdata;

  function automatic logic [DW-1:0] init_val(input int unsigned a);
    return DW'(a * 37 + 32'h1000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every ack pops the oldest expected transaction.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && (bus.cpu_ack === 1'b1 || bus.per_ack === 1'b1)) begin
      if (bus.per_ack === 1'b1) per_ack_cnt++;
      n_vec++;
      assert (!(bus.cpu_ack === 1'b1 && bus.per_ack === 1'b1)) else begin
        n_err++;
        $error("FAIL dual_ack: observed cpu_ack=%b per_ack=%b expected one-hot", bus.cpu_ack, bus.per_ack);
      end
      n_vec++;
      assert (sbq.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_ack: observed cpu_ack=%b per_ack=%b expected no ack", bus.cpu_ack, bus.per_ack);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        n_vec++;
        assert (bus.per_ack === e.per) else begin
          n_err++;
          $error("FAIL ack_owner: observed per_ack=%b expected per_ack=%b", bus.per_ack, e.per);
        end
        if (e.rd) begin
          n_vec++;
          assert ((e.per ? bus.per_rdata : bus.cpu_rdata) === e.data) else begin
            n_err++;
            $error("FAIL ack_rdata: observed %h expected %h",
                   e.per ? bus.per_rdata : bus.cpu_rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected $finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = init_val(unsigned'(i));
    mem[16'h0010] = 16'hBEEF;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_wdata = '0;
    bus.per_req = 1'b1; bus.per_we = 1'b0; bus.per_addr = 16'h0100; bus.per_wdata = '0;

    // Reset held with both requests high
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {bus.mem_we, bus.cpu_ack, bus.per_ack, bus.busy, bus.owner}, '0);
    chk("reset_mem_addr", bus.mem_addr, '0);
    chk("reset_mem_wdata", bus.mem_wdata, '0);
    chk("reset_rdata", {bus.cpu_rdata, bus.per_rdata}, '0);

    // CPU read of 0x0010 granted on the first edge after release
    bus.per_req = 1'b0;
    rst = 1'b1;
    sbq.push_back('{per: 1'b0, rd: 1'b1, data: 16'hBEEF});
    @(negedge clk);
    chk("cpu_rd_issue_busy", {bus.busy, bus.owner, bus.mem_we}, {1'b1, OWNER_CPU, 1'b0});
    chk("cpu_rd_issue_addr", bus.mem_addr, 16'h0010);
    chk("cpu_rd_issue_noack", {bus.cpu_ack, bus.per_ack}, 2'b00);
    @(negedge clk);
    chk("cpu_rd_ack", {bus.cpu_ack, bus.per_ack}, 2'b10);
    chk("cpu_rd_data", bus.cpu_rdata, 16'hBEEF);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("cpu_rd_idle", bus.busy, 1'b0);

    // Simultaneous requests: CPU first, peripheral write next
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
    bus.per_req = 1'b1; bus.per_we = 1'b1; bus.per_addr = 16'h00FF; bus.per_wdata = 16'h1234;
    sbq.push_back('{per: 1'b0, rd: 1'b1, data: init_val(32'h20)});
    sbq.push_back('{per: 1'b1, rd: 1'b0, data: '0});
    @(negedge clk);
    chk("sim_issue_owner", bus.owner, OWNER_CPU);
    @(negedge clk);
    chk("sim_cpu_ack", {bus.cpu_ack, bus.per_ack}, 2'b10);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("sim_per_issue", {bus.mem_we, bus.owner, bus.busy}, {1'b1, OWNER_PER, 1'b1});
    chk("sim_per_addr", bus.mem_addr, 16'h00FF);
    chk("sim_per_wdata", bus.mem_wdata, 16'h1234);
    @(negedge clk);
    chk("sim_per_ack", {bus.cpu_ack, bus.per_ack}, 2'b01);
    bus.per_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h00FF;
    sbq.push_back('{per: 1'b0, rd: 1'b1, data: 16'h1234});
    @(negedge clk);
    @(negedge clk);
    chk("readback_ff", bus.cpu_rdata, 16'h1234);
    bus.cpu_req = 1'b0;
    @(negedge clk);

    // Starvation: expected grant order C C C C P C
    per_ack_base = per_ack_cnt;
    bus.per_req = 1'b1; bus.per_we = 1'b0; bus.per_addr = 16'h0100;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001;
    for (int unsigned a = 1; a <= 4; a++) sbq.push_back('{per: 1'b0, rd: 1'b1, data: init_val(a)});
    sbq.push_back('{per: 1'b1, rd: 1'b1, data: init_val(32'h100)});
    sbq.push_back('{per: 1'b0, rd: 1'b1, data: init_val(32'h5)});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      @(negedge clk);
      if (k < 4) bus.cpu_addr = AW'(k + 2);
      if (k == 4) begin
        chk("starve_per_rdata", bus.per_rdata, init_val(32'h100));
        bus.per_req = 1'b0;
      end
      if (k == 5) bus.cpu_req = 1'b0;
    end
    @(negedge clk);
    chk("starve_per_once", per_ack_cnt - per_ack_base, 1);
    chk("starve_idle", bus.busy, 1'b0);

    // Peripheral drops req during ISSUE of its write
    bus.per_req = 1'b1; bus.per_we = 1'b1; bus.per_addr = 16'h0040; bus.per_wdata = 16'h5A5A;
    sbq.push_back('{per: 1'b1, rd: 1'b0, data: '0});
    @(negedge clk);
    chk("drop_issue_we", bus.mem_we, 1'b1);
    bus.per_req = 1'b0;
    @(negedge clk);
    chk("drop_ack", {bus.cpu_ack, bus.per_ack}, 2'b01);
    @(negedge clk);
    chk("drop_idle", {bus.busy, bus.per_ack}, 2'b00);
    chk("drop_mem", mem[9'h040], 16'h5A5A);

    // Reset during ISSUE of a CPU write abandons it
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0030; bus.cpu_wdata = 16'hCAFE;
    @(negedge clk);
    chk("rst_issue_we", bus.mem_we, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_we_drop", {bus.mem_we, bus.busy, bus.cpu_ack}, 3'b000);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_no_ack", {bus.cpu_ack, bus.per_ack}, 2'b00);
    chk("rst_mem_kept", mem[9'h030], init_val(32'h30));
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_after_idle", bus.busy, 1'b0);
    chk("rst_after_mem", mem[9'h030], init_val(32'h30));
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
